// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_pkg : opcodes and FSM states shared by the calc_stack slice   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package calc_pkg;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_LSL  = 3'b110;
  localparam logic [2:0] OP_ASR  = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_stack_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_stack_if : board buttons/switches in, LEDs and status out     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface calc_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             btnd;
  logic             btnl;
  logic             btnc;
  logic             btnr;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] led;
  logic             busy;
  logic             err;
  logic             ovf;
  logic [CW-1:0]    cnt;

  modport master (
    output btnd, btnl, btnc, btnr, sw,
    input  led, busy, err, ovf, cnt
  );

  modport slave (
    input  btnd, btnl, btnc, btnr, sw,
    output led, busy, err, ovf, cnt
  );

endinterface
`default_nettype wire

// File: rtl/calc_serial_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_serial_shifter : one-bit-per-cycle LSL / ASR engine           |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module calc_serial_shifter
  import calc_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(WIDTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic             dir,     // 0: logical left, 1: arithmetic right
  input  wire logic [WIDTH-1:0] din,
  input  wire logic [AW-1:0]    amt,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result
);

  logic             r_active;
  logic             r_dir;
  logic [AW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_dir    <= 1'b0;
      r_count  <= '0;
      r_data   <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_dir    <= dir;
      r_count  <= amt;
      r_data   <= din;
    end else if (r_active) begin
      if (r_count != '0) begin
        r_count <= r_count - AW'(1);
        r_data  <= r_dir ? {r_data[WIDTH-1], r_data[WIDTH-1:1]}
                         : {r_data[WIDTH-2:0], 1'b0};
      end else begin
        r_active <= 1'b0;
      end
    end
  end

  // done is high during the final busy cycle so the owner commits on that edge
  assign busy   = r_active;
  assign done   = r_active && (r_count == '0);
  assign result = r_data;

endmodule
`default_nettype wire

// File: rtl/calc_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_stack : RPN stack calculator with serial shift engine         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module calc_stack
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input wire logic    clk,
  input wire logic    btnu,
  calc_stack_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_t           r_state;
  logic             r_btnd_q;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic             r_ovf;

  logic [2:0]       w_op;
  logic             w_fire;
  logic             w_is_shift;
  logic             w_has_two;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_n;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_ovf;
  logic             w_wr_en;
  logic [CW-1:0]    w_wr_slot;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_sh_start;
  logic             w_sh_busy;
  logic             w_sh_done;
  logic [WIDTH-1:0] w_sh_result;

  assign w_op       = {bus.btnl, bus.btnc, bus.btnr};
  assign w_fire     = bus.btnd & ~r_btnd_q & ~w_sh_busy;
  assign w_is_shift = (w_op == OP_LSL) || (w_op == OP_ASR);
  assign w_has_two  = (r_cnt >= CW'(2));
  assign w_sh_start = (r_state == S_IDLE) && w_fire && w_is_shift && w_has_two;

  // Stack is addressed by occupancy, so pick T and N by matching slot numbers
  always_comb begin
    w_t = '0;
    w_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == r_cnt - CW'(1)) w_t = r_stack[i];
      if (CW'(i) == r_cnt - CW'(2)) w_n = r_stack[i];
    end
  end

  assign w_sum  = w_n + w_t;
  assign w_diff = w_n - w_t;

  always_comb begin
    w_alu     = '0;
    w_alu_ovf = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alu     = w_sum;
        w_alu_ovf = (w_n[M] == w_t[M]) && (w_sum[M] != w_n[M]);
      end
      OP_SUB: begin
        w_alu     = w_diff;
        w_alu_ovf = (w_n[M] != w_t[M]) && (w_diff[M] != w_n[M]);
      end
      OP_AND:  w_alu = w_n & w_t;
      OP_OR:   w_alu = w_n | w_t;
      OP_XOR:  w_alu = w_n ^ w_t;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_slot = r_cnt;
    w_wr_data = bus.sw;
    if (r_state == S_IDLE && w_fire) begin
      if (w_op == OP_PUSH) begin
        w_wr_en = (r_cnt != CW'(DEPTH));
      end else if (!w_is_shift && w_has_two) begin
        w_wr_en   = 1'b1;
        w_wr_slot = r_cnt - CW'(2);
        w_wr_data = w_alu;
      end
    end else if (r_state == S_SHIFT && w_sh_done) begin
      w_wr_en   = 1'b1;
      w_wr_slot = r_cnt - CW'(2);
      w_wr_data = w_sh_result;
    end
  end

  always_ff @(posedge clk) begin
    if (btnu) begin
      r_state  <= S_IDLE;
      r_btnd_q <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_btnd_q <= bus.btnd;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_en && CW'(i) == w_wr_slot) r_stack[i] <= w_wr_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            if (w_op == OP_PUSH) begin
              if (r_cnt == CW'(DEPTH)) begin
                r_err <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CW'(1);
                r_err <= 1'b0;
                r_ovf <= 1'b0;
              end
            end else if (!w_has_two) begin
              r_err <= 1'b1;
            end else if (w_is_shift) begin
              r_state <= S_SHIFT;
              r_err   <= 1'b0;
              r_ovf   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
              r_err <= 1'b0;
              r_ovf <= w_alu_ovf;
            end
          end
        end
        S_SHIFT: begin
          if (w_sh_done) begin
            r_cnt   <= r_cnt - CW'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  calc_serial_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk    (clk),
    .rst    (btnu),
    .start  (w_sh_start),
    .dir    (w_op == OP_ASR),
    .din    (w_n),
    .amt    (w_t[AW-1:0]),
    .busy   (w_sh_busy),
    .done   (w_sh_done),
    .result (w_sh_result)
  );

  assign bus.led  = (r_cnt == '0) ? '0 : w_t;
  assign bus.busy = w_sh_busy;
  assign bus.err  = r_err;
  assign bus.ovf  = r_ovf;
  assign bus.cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_calc_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_calc_stack : directed self-checking bench for calc_stack        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_calc_stack;

  logic clk;
  logic btnu;
  int   n_cmp;
  int   n_bad;

  calc_stack_if #(.WIDTH(16), .DEPTH(4)) bus ();

  calc_stack #(.WIDTH(16), .DEPTH(4)) dut (
    .clk  (clk),
    .btnu (btnu),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    btnu     = 1'b1;
    bus.btnd = 1'b0;
    @(negedge clk);
    btnu = 1'b0;
  endtask

  // Returns at the negedge just after the accepting posedge
  task automatic issue(input logic [2:0] op, input logic [15:0] v);
    @(negedge clk);
    {bus.btnl, bus.btnc, bus.btnr} = op;
    bus.sw   = v;
    bus.btnd = 1'b1;
    @(negedge clk);
    bus.btnd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.led !== 16'h0000) begin n_bad++; $display("FAIL reset_led: got %h want 0000", bus.led); end
    n_cmp++; if (bus.cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.cnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_sub();
    do_reset();
    issue(3'b000, 16'h354A);
    issue(3'b000, 16'h1234);
    issue(3'b010, 16'h0000);
    n_cmp++; if (bus.led !== 16'h2316) begin n_bad++; $display("FAIL sub_led: got %h want 2316", bus.led); end
    n_cmp++; if (bus.cnt !== 3'd1) begin n_bad++; $display("FAIL sub_cnt: got %0d want 1", bus.cnt); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL sub_ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_add_ovf();
    do_reset();
    issue(3'b000, 16'h7FFF);
    issue(3'b000, 16'h0001);
    issue(3'b001, 16'h0000);
    n_cmp++; if (bus.led !== 16'h8000) begin n_bad++; $display("FAIL add_led: got %h want 8000", bus.led); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL add_ovf: got %b want 1", bus.ovf); end
    n_cmp++; if (bus.cnt !== 3'd1) begin n_bad++; $display("FAIL add_cnt: got %0d want 1", bus.cnt); end
    issue(3'b000, 16'h0005);
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL push_clr_ovf: got %b want 0", bus.ovf); end
    n_cmp++; if (bus.led !== 16'h0005) begin n_bad++; $display("FAIL push_led: got %h want 0005", bus.led); end
  endtask

  task automatic test_logic_ops();
    do_reset();
    issue(3'b000, 16'hF0F0);
    issue(3'b000, 16'h3C3C);
    issue(3'b011, 16'h0000);
    n_cmp++; if (bus.led !== 16'h3030) begin n_bad++; $display("FAIL and_led: got %h want 3030", bus.led); end
    issue(3'b000, 16'h0F00);
    issue(3'b100, 16'h0000);
    n_cmp++; if (bus.led !== 16'h3F30) begin n_bad++; $display("FAIL or_led: got %h want 3F30", bus.led); end
    issue(3'b000, 16'hFFFF);
    issue(3'b101, 16'h0000);
    n_cmp++; if (bus.led !== 16'hC0CF) begin n_bad++; $display("FAIL xor_led: got %h want C0CF", bus.led); end
    issue(3'b000, 16'h8000);
    issue(3'b000, 16'h0001);
    issue(3'b010, 16'h0000);
    n_cmp++; if (bus.led !== 16'h7FFF) begin n_bad++; $display("FAIL subovf_led: got %h want 7FFF", bus.led); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL subovf_ovf: got %b want 1", bus.ovf); end
    n_cmp++; if (bus.cnt !== 3'd2) begin n_bad++; $display("FAIL subovf_cnt: got %0d want 2", bus.cnt); end
    issue(3'b011, 16'h0000);
    n_cmp++; if (bus.led !== 16'h40CF) begin n_bad++; $display("FAIL and2_led: got %h want 40CF", bus.led); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL and2_ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_lsl();
    int n;
    do_reset();
    issue(3'b000, 16'h0015);
    issue(3'b000, 16'h0004);
    issue(3'b110, 16'h0000);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) bus.btnd = 1'b1;
      if (n == 4) bus.btnd = 1'b0;
      @(negedge clk);
    end
    bus.btnd = 1'b0;
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL lsl_busy_cycles: got %0d want 5", n); end
    n_cmp++; if (bus.led !== 16'h0150) begin n_bad++; $display("FAIL lsl_led: got %h want 0150", bus.led); end
    n_cmp++; if (bus.cnt !== 3'd1) begin n_bad++; $display("FAIL lsl_cnt: got %0d want 1", bus.cnt); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.cnt !== 3'd1) begin n_bad++; $display("FAIL lsl_drop_edge: got %0d want 1", bus.cnt); end
  endtask

  task automatic test_asr();
    int n;
    do_reset();
    issue(3'b000, 16'hF000);
    issue(3'b000, 16'h0003);
    issue(3'b111, 16'h0000);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL asr_busy_cycles: got %0d want 4", n); end
    n_cmp++; if (bus.led !== 16'hFE00) begin n_bad++; $display("FAIL asr_led: got %h want FE00", bus.led); end
  endtask

  task automatic test_shift_zero();
    int n;
    do_reset();
    issue(3'b000, 16'h1234);
    issue(3'b000, 16'h0010);
    issue(3'b110, 16'h0000);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL shift0_busy_cycles: got %0d want 1", n); end
    n_cmp++; if (bus.led !== 16'h1234) begin n_bad++; $display("FAIL shift0_led: got %h want 1234", bus.led); end
  endtask

  task automatic test_errors();
    do_reset();
    for (int i = 1; i <= 5; i++) issue(3'b000, 16'(i));
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL full_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.cnt !== 3'd4) begin n_bad++; $display("FAIL full_cnt: got %0d want 4", bus.cnt); end
    n_cmp++; if (bus.led !== 16'h0004) begin n_bad++; $display("FAIL full_led: got %h want 0004", bus.led); end
    do_reset();
    issue(3'b000, 16'h0007);
    issue(3'b001, 16'h0000);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL under_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.led !== 16'h0007) begin n_bad++; $display("FAIL under_led: got %h want 0007", bus.led); end
    n_cmp++; if (bus.cnt !== 3'd1) begin n_bad++; $display("FAIL under_cnt: got %0d want 1", bus.cnt); end
    issue(3'b000, 16'h0008);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", bus.err); end
  endtask

  task automatic test_hold();
    do_reset();
    @(negedge clk);
    {bus.btnl, bus.btnc, bus.btnr} = 3'b000;
    bus.sw   = 16'h0011;
    bus.btnd = 1'b1;
    repeat (4) @(negedge clk);
    bus.btnd = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cnt !== 3'd1) begin n_bad++; $display("FAIL hold_cnt: got %0d want 1", bus.cnt); end
  endtask

  task automatic test_reset_dominates();
    do_reset();
    @(negedge clk);
    {bus.btnl, bus.btnc, bus.btnr} = 3'b000;
    bus.sw   = 16'h00AA;
    bus.btnd = 1'b1;
    btnu     = 1'b1;
    @(negedge clk);
    btnu     = 1'b0;
    bus.btnd = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cnt !== 3'd0) begin n_bad++; $display("FAIL rst_dom_cnt: got %0d want 0", bus.cnt); end
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    issue(3'b000, 16'h0001);
    issue(3'b000, 16'h000F);
    issue(3'b110, 16'h0000);
    repeat (3) @(negedge clk);
    btnu = 1'b1;
    @(negedge clk);
    btnu = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.led !== 16'h0000) begin n_bad++; $display("FAIL midrst_led: got %h want 0000", bus.led); end
    n_cmp++; if (bus.cnt !== 3'd0) begin n_bad++; $display("FAIL midrst_cnt: got %0d want 0", bus.cnt); end
    n_cmp++; if (bus.err !== 1'b0 || bus.ovf !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got err=%b ovf=%b want 0 0", bus.err, bus.ovf); end
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.cnt !== 3'd0 || bus.led !== 16'h0000) begin n_bad++; $display("FAIL midrst_late: got cnt=%0d led=%h want 0 0000", bus.cnt, bus.led); end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    btnu     = 1'b1;
    bus.btnd = 1'b0;
    bus.btnl = 1'b0;
    bus.btnc = 1'b0;
    bus.btnr = 1'b0;
    bus.sw   = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_sub();
    test_add_ovf();
    test_logic_ops();
    test_lsl();
    test_asr();
    test_shift_zero();
    test_errors();
    test_hold();
    test_reset_dominates();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_stack.md
# calc_stack

Parametrised RPN stack calculator, successor to the single-accumulator `calc` board top. Operands are pushed from the switches onto a DEPTH-entry stack. Binary ALU operations consume the two top entries and push the result. Shifts run on a serial one-bit-per-cycle engine with a busy indication. The block sits directly behind the board buttons/switches and drives the LEDs; button debouncing stays outside it.

## Interface
Parameters:
- `WIDTH`, 16: datapath, switch and LED width; must be ≥ 4.
- `DEPTH`, 4: stack entries; must be ≥ 2.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `btnu`  in  1: reset, synchronous, active-high.
- `btnd`  in  1: execute button, level; its rising edge issues one command.
- `btnl`, `btnc`, `btnr`  in  1 each: opcode `op = {btnl,btnc,btnr}`.
- `sw`  in  WIDTH: push operand.
- `led`  out  WIDTH: top of stack; 0 when the stack is empty.
- `busy`  out  1: a shift is in progress.
- `err`  out  1: the last issued command was rejected (stack full or underflow).
- `ovf`  out  1: the last completed ADD/SUB had a signed overflow.
- `cnt`  out  $clog2(DEPTH+1): number of valid entries.

## Operation
- `btnd_q` registers `btnd`. A command is accepted at a posedge where `btnd & ~btnd_q & ~busy`.
- An edge that occurs while `busy` is dropped, not queued.
- T = top of stack (entry cnt-1), N = next (entry cnt-2). All arithmetic is two's complement, WIDTH bits, wrapping.
- Opcodes:
  - 000 PUSH: push `sw`.
  - 001 ADD: N+T.
  - 010 SUB: N−T.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 LSL: N << T[$clog2(WIDTH)-1:0], zero fill.
  - 111 ASR: N >>> same amount, sign fill.
- Binary ops write the result into entry cnt-2 and set cnt to cnt-1.
- PUSH with cnt==DEPTH: err=1; stack, cnt and ovf are unchanged.
- Binary op with cnt<2: err=1; stack, cnt and ovf are unchanged.
- Every accepted command clears err, unless that command itself sets err. ovf is updated only by ADD/SUB and cleared by any other accepted command.
- ovf = operand signs equal and result sign differs (for SUB, T's sign is inverted first).
- FSM states:
  - IDLE → SHIFT when LSL/ASR is accepted with cnt≥2. On entry, load operand N and count = amount.
  - SHIFT: each posedge, if count≠0, shift by 1 and decrement count. If count==0, write the result, pop, and return to IDLE.
- `led`, `cnt`, `err` and `ovf` are registered or derived only from registers; there is no combinational path from `sw` or the buttons.

## Timing
- Reset values: stack entries 0, cnt 0, led 0, busy 0, err 0, ovf 0, state IDLE, btnd_q 0.
- `btnu` dominates: reset at a posedge with `btnd` high performs no command.
- Reset mid-shift aborts the shift and clears everything.
- PUSH and the non-shift ALU ops: accepted at posedge P; led, cnt, err and ovf reflect the result after P (1-cycle latency).
- Shift by k: accepted at P, busy=1 after P. The result is written and busy=0 after posedge P+k+1, so busy is high for k+1 cycles; k=0 gives 1 busy cycle.
- During SHIFT, led still shows the old T and cnt is unchanged until completion.
- Holding `btnd` high issues exactly one command. A new command needs `btnd` low for at least 1 cycle.

## Structure
- Package `calc_pkg` holds:
  - opcode localparams: OP_PUSH, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LSL, OP_ASR;
  - the state enum {S_IDLE, S_SHIFT}.
- Sub-module `calc_serial_shifter` (WIDTH parameter): load/start, direction, amount in; busy, done pulse and result out.
- The top level holds the edge detect, the stack register array, cnt/err/ovf and the combinational single-cycle ALU.

## Test plan
All scenarios use WIDTH=16, DEPTH=4.
- Reset: drive `btnu` 1 cycle → led=0x0000, cnt=0, busy=0, err=0, ovf=0.
- SUB: push 0x354A, push 0x1234, op 010 → led=0x2316, cnt=1, ovf=0.
- ADD overflow: push 0x7FFF, push 0x0001, op 001 → led=0x8000, ovf=1. A following PUSH clears ovf.
- LSL: push 0x0015, push 0x0004, op 110 → busy high exactly 5 cycles, then led=0x0150, cnt=1. A `btnd` edge during busy is ignored (cnt stays 1).
- ASR: push 0xF000, push 0x0003, op 111 → led=0xFE00 after 4 busy cycles.
- Error cases:
  - 5 pushes (1,2,3,4,5) → err=1, cnt=4, led=0x0004.
  - Reset, push 0x0007, ADD → err=1, led=0x0007, cnt=1.
  - Reset asserted mid-shift → all outputs return to 0 the next cycle.
